mips_divider: RTL and testbench
===============================

// Module: mips_divider
// PURPOSE
//  Iterative radix-2 restoring divider for MIPS DIV/DIVU, the inverse of the ALU's single-cycle MUL.
//  Sits beside the ALU in EX; the decode/stall logic issues a request and stalls the pipe while div_busy is high.
//  Quotient/remainder are written to HI/LO on div_done.
// PARAMETERS
//  WIDTH   32  operand/result width; iteration count = WIDTH
//  CNT_W   6   iteration counter width, must be >= clog2(WIDTH)+1
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  div_start      in   1      request; sampled only in IDLE or DONE
//  div_signed     in   1      1 = DIV (two's complement), 0 = DIVU
//  div_dividend   in   WIDTH  rs operand, captured on accepted start
//  div_divisor    in   WIDTH  rt operand, captured on accepted start
//  div_flush      in   1      synchronous cancel (branch/exception squash)
//  div_busy       out  1      high in CALC and FIX states
//  div_done       out  1      one-cycle pulse, results valid
//  div_quotient   out  WIDTH  to LO; held until the next accepted start
//  div_remainder  out  WIDTH  to HI; held until the next accepted start
//  div_by_zero    out  1      divisor was zero, valid with div_done and held
// BEHAVIOUR
//  Reset: state IDLE; busy, done, by_zero = 0; quotient, remainder = 0; counter = 0.
//  States: IDLE -start-> CALC -(cnt==WIDTH-1)-> FIX -> DONE -> IDLE. DONE + start -> CALC directly.
//  Start accepted in cycle N: operands latched; signed mode stores magnitudes and sign bits.
//  Cycles N+1..N+WIDTH are CALC, one restoring step each (shift rem:quo left, trial subtract, set q bit).
//  Cycle N+WIDTH+1 is FIX: sign correction applied, outputs registered.
//  div_done is high in cycle N+WIDTH+2, so latency = 34 cycles at WIDTH=32.
//  Start while busy is ignored, with no queueing.
//  Signed rules: quotient truncates toward zero, negated iff the operand signs differ; remainder takes the dividend's sign.
//  Magnitudes are WIDTH-bit unsigned, so |-2^31| is representable.
//  -2^31 / -1 -> quotient 32'h80000000, remainder 0, no trap.
//  Divisor 0 -> quotient 32'hFFFFFFFF, remainder = raw dividend, div_by_zero = 1; same latency.
//  div_flush in any state -> IDLE next cycle with no done pulse; outputs keep their previous values.
//  If flush and start occur in the same cycle, flush wins.
//  rst_n low at any time, including mid-CALC -> immediate reset values.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in the cycle after accept, if |dividend| < |divisor| (divisor != 0), skip CALC.
//    Go to FIX with quotient 0 and remainder = dividend; done arrives 3 cycles after start.
//  DIV_EARLY_OUT_EN undefined: every divide takes the full WIDTH+2 cycles; outputs are identical.
// STRUCTURE
//  mips_defines.v gains DIV_IDLE/DIV_CALC/DIV_FIX/DIV_DONE 2-bit state encodings and DIV_ITERS (32).
//  Sub-module mips_div_step is combinational: {rem_in, quo_in, divisor} -> {rem_out, quo_out}.
//    It performs one shift/trial-subtract/restore; instantiated once, iterated by the FSM.
//  Top level holds the FSM, counter, sign capture and fixup.
// TESTING
//  DIVU 100 / 7 -> done at start+34; quotient 14, remainder 2, by_zero 0.
//  DIV -7 / 2 -> quotient 32'hFFFFFFFD (-3), remainder 32'hFFFFFFFF (-1);
//    DIV 7 / -2 -> quotient -3, remainder 1.
//  DIV 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0.
//    DIVU of the same operands -> quotient 0, remainder 32'h80000000.
//  DIVU 5 / 0 -> quotient 32'hFFFFFFFF, remainder 5, by_zero 1, same latency.
//  Start at cycle 0, flush at cycle 10 -> busy low at 11, no done; a new start at 12 completes normally.
//    Repeat with rst_n pulsed low mid-CALC -> all outputs 0 immediately.
//  Back-to-back: start asserted during DONE -> accepted; second done 34 cycles later.
//    Under DIV_EARLY_OUT_EN, DIVU 3 / 9 -> done at start+3, quotient 0, remainder 3.

Source files
------------

// File: rtl/mips_divider_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit: FSM encodings and default iteration count.
package mips_divider_pkg;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/mips_div_step.sv
// One restoring division step: shift rem:quo left by one, trial-subtract divisor, restore on borrow.
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    ge      = shifted >= {1'b0, divisor};
    // when ge holds the true difference is < 2^WIDTH, so the low bits are exact
    diff    = shifted[WIDTH-1:0] - divisor;
    rem_out = ge ? diff : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/mips_divider.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU with sign capture and fixup.
// Optional DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  input  logic             div_flush,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_by_zero
);
  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r, step_rem, step_quo;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, fixed_q, fixed_r;
  logic             quo_neg, rem_neg, dz_r;
  logic             dvd_neg, dvs_neg, accept, last_iter, early;

  mips_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (dvs_r),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign dvd_neg   = div_signed & div_dividend[WIDTH-1];
  assign dvs_neg   = div_signed & div_divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -div_dividend : div_dividend;
  assign dvs_mag   = dvs_neg ? -div_divisor : div_divisor;
  assign accept    = (state == DIV_IDLE || state == DIV_DONE) && div_start && !div_flush;
  assign last_iter = (state == DIV_CALC) && (cnt == CNT_W'(WIDTH - 1));
  assign div_busy  = (state == DIV_CALC) || (state == DIV_FIX);

`ifdef DIV_EARLY_OUT_EN
  // quo_r still holds the unshifted dividend magnitude on the first CALC cycle
  assign early = (state == DIV_CALC) && (cnt == '0) && !dz_r && (quo_r < dvs_r);
`else
  assign early = 1'b0;
`endif

  // divide-by-zero: the restoring loop naturally yields all-ones and the dividend magnitude
  assign fixed_q = dz_r ? '1 : (quo_neg ? -quo_r : quo_r);
  assign fixed_r = rem_neg ? -rem_r : rem_r;

  always_comb begin
    state_nxt = state;
    if (div_flush) state_nxt = DIV_IDLE;
    else begin
      case (state)
        DIV_IDLE: if (div_start) state_nxt = DIV_CALC;
        DIV_CALC: if (last_iter || early) state_nxt = DIV_FIX;
        DIV_FIX:  state_nxt = DIV_DONE;
        DIV_DONE: state_nxt = div_start ? DIV_CALC : DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      rem_r         <= '0;
      quo_r         <= '0;
      dvs_r         <= '0;
      quo_neg       <= 1'b0;
      rem_neg       <= 1'b0;
      dz_r          <= 1'b0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      div_done <= (state == DIV_FIX) && !div_flush;
      if (accept) begin
        cnt     <= '0;
        rem_r   <= '0;
        quo_r   <= dvd_mag;
        dvs_r   <= dvs_mag;
        quo_neg <= dvd_neg ^ dvs_neg;
        rem_neg <= dvd_neg;
        dz_r    <= (div_divisor == '0);
      end else if (state == DIV_CALC && !div_flush) begin
        cnt <= cnt + 1'b1;
        if (early) begin
          rem_r <= quo_r;
          quo_r <= '0;
        end else begin
          rem_r <= step_rem;
          quo_r <= step_quo;
        end
      end
      if (state == DIV_FIX && !div_flush) begin
        div_quotient  <= fixed_q;
        div_remainder <= fixed_r;
        div_by_zero   <= dz_r;
      end
    end
  end
endmodule

// File: tb/tb_mips_divider.sv
// Scoreboard bench for mips_divider: stimulus pushes model results, a monitor checks each done pulse.
module tb_mips_divider;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         div_start = 1'b0, div_signed = 1'b0, div_flush = 1'b0;
  logic [W-1:0] div_dividend = '0, div_divisor = '0;
  logic         div_busy, div_done, div_by_zero;
  logic [W-1:0] div_quotient, div_remainder;

  mips_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_flush(div_flush),
    .div_busy(div_busy), .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint mag(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero, remainder follows dividend
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int now);
    exp_t   e;
    longint sa, sd, q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sd = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      q = sa / sd; r = sa % sd;
      e.q = 32'(q); e.r = 32'(r); e.dz = 1'b0;
    end
    e.due = now + 34;
`ifdef DIV_EARLY_OUT_EN
    if (b != '0 && mag(sa) < mag(sd)) e.due = now + 3;
`endif
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && div_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", div_quotient, e.q);
          chk("remainder", div_remainder, e.r);
          chk("by_zero", div_by_zero, e.dz);
          chk("latency_cycle", cyc, e.due);
          last = e;
        end
      end
    end
  end

  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge clk);
    div_start = 1'b1; div_signed = sgn; div_dividend = a; div_divisor = b;
    if (push) sb.push_back(model(sgn, a, b, cyc));
    @(negedge clk);
    div_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=pending required=done (cycle %0d)", cyc);
      sb.delete();
    end
  endtask

  logic         t_sgn [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] t_a   [8] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000, 32'd5, 32'd3, 32'h80000000};
  logic [W-1:0] t_b   [8] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd9, 32'd0};

  initial begin : stim
    int k, n;
    logic [W-1:0] a, b;
    logic sgn;

    repeat (3) @(negedge clk);
    chk("reset_quotient", div_quotient, 0);
    chk("reset_remainder", div_remainder, 0);
    chk("reset_busy", div_busy, 0);
    chk("reset_done", div_done, 0);
    chk("reset_by_zero", div_by_zero, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(t_sgn[i], t_a[i], t_b[i], 1'b1);
      wait_drain(60);
      @(negedge clk);
      if (i == 0) begin
        chk("divu_100_7_q", div_quotient, 14);
        chk("divu_100_7_r", div_remainder, 2);
      end
      if (i == 1) begin
        chk("div_m7_2_q", div_quotient, 32'hFFFFFFFD);
        chk("div_m7_2_r", div_remainder, 32'hFFFFFFFF);
      end
      if (i == 5) chk("divu_5_0_q", div_quotient, 32'hFFFFFFFF);
    end

    // start while busy is ignored
    issue(1'b0, 32'd1000, 32'd10, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_in_calc", div_busy, 1);
    issue(1'b0, 32'd55, 32'd5, 1'b0);
    wait_drain(60);
    @(negedge clk);

    // flush mid-CALC, then a fresh start two cycles later
    @(negedge clk);
    div_start = 1'b1; div_signed = 1'b0; div_dividend = 32'd12345; div_divisor = 32'd67;
    k = cyc;
    @(negedge clk);
    div_start = 1'b0;
    while (cyc < k + 10) @(negedge clk);
    chk("busy_before_flush", div_busy, 1);
    div_flush = 1'b1;
    @(negedge clk);
    div_flush = 1'b0;
    chk("busy_after_flush", div_busy, 0);
    chk("held_quotient", div_quotient, last.q);
    chk("held_remainder", div_remainder, last.r);
    issue(1'b0, 32'd12345, 32'd67, 1'b1);
    wait_drain(60);

    // asynchronous reset mid-CALC
    issue(1'b1, -32'sd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_quotient", div_quotient, 0);
    chk("rst_mid_remainder", div_remainder, 0);
    chk("rst_mid_busy", div_busy, 0);
    chk("rst_mid_done", div_done, 0);
    chk("rst_mid_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, -32'sd1000, 32'd3, 1'b1);
    wait_drain(60);

    // back-to-back: second start issued in the DONE cycle
    issue(1'b0, 32'd200, 32'd3, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!div_done && n < 60);
    div_start = 1'b1; div_signed = 1'b1; div_dividend = 32'hFFFFFF00; div_divisor = 32'd7;
    sb.push_back(model(1'b1, 32'hFFFFFF00, 32'd7, cyc));
    @(negedge clk);
    div_start = 1'b0;
    wait_drain(60);

    for (int i = 0; i < 60; i++) begin
      sgn = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = 32'($signed(-$urandom_range(1, 300)));
        3: b = '0;
        default: b = a >> $urandom_range(0, 40);
      endcase
      issue(sgn, a, b, 1'b1);
      wait_drain(60);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
